// File: rtl/risc_loader_pkg.sv
`timescale 1ns/1ps
// risc_loader_pkg: shared encodings for the Risc_top program loader.
// FSM states, error codes, CPU opcodes (3-bit, used by benches to build
// programs) and the CPU reset hold length after a load.
package risc_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_VERIFY = 3'd2,
    ST_CPURST = 3'd3,
    ST_RUN    = 3'd4,
    ST_DONE   = 3'd5
  } loader_state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_VERIFY  = 2'd2;

  // Risc_top instruction byte is {opcode[2:0], operand_addr[4:0]}
  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  // clocks the CPU reset stays high between loading and running
  localparam int CPURST_HOLD = 2;

  // a new load may only be started from a resting state
  function automatic logic is_idle_or_done(input loader_state_t s);
    return (s == ST_IDLE) || (s == ST_DONE);
  endfunction

endpackage

// File: rtl/risc_prog_loader_timer.sv
`timescale 1ns/1ps
// risc_run_timer: saturating run-clock counter for the loader.
// clear wins over enable; enable low freezes the count. expire flags that
// the current enabled clock is the one that brings the count to TIMEOUT.
module risc_run_timer #(
  parameter int CYC_W   = 16,
  parameter int TIMEOUT = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  output logic [CYC_W-1:0] count,
  output logic             expire
);

  localparam logic [CYC_W-1:0] LIMIT    = CYC_W'(TIMEOUT);
  localparam logic [CYC_W-1:0] LIMIT_M1 = CYC_W'(TIMEOUT - 1);

  // count enabled clocks, never past TIMEOUT
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LIMIT)) begin
      count <= count + 1'b1;
    end
  end

  assign expire = enable && (count == LIMIT_M1);

endmodule

// File: rtl/risc_prog_loader.sv
`timescale 1ns/1ps
// risc_prog_loader: streams a program into the Risc_top memory, holds the CPU
// in reset for a fixed time, then runs it and counts clocks until halt or
// timeout. Optional read-back check of the loaded image is enabled by
// defining RISC_LOADER_VERIFY_EN.
module risc_prog_loader
  import risc_loader_pkg::*;
#(
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 8,
  parameter int CYC_W   = 16,
  parameter int TIMEOUT = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              mem_we,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              cpu_rst,
  input  logic              halt,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err_code,
  output logic [CYC_W-1:0]  cycles
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [1:0]        HOLD_LAST = 2'(CPURST_HOLD - 1);

  loader_state_t     state_reg;
  logic [ADDR_W-1:0] ptr_reg;
  logic [1:0]        hold_reg;

  logic start_take;
  logic handshake;
  logic load_end;
  logic timer_en;
  logic timer_expire;

  assign start_take = start && is_idle_or_done(state_reg);
  assign handshake  = (state_reg == ST_LOAD) && in_valid && in_ready;
  // the last byte is either flagged or the one landing on the top address
  assign load_end   = handshake && (in_last || (ptr_reg == LAST_ADDR));
  assign timer_en   = (state_reg == ST_RUN) && !halt;

  risc_run_timer #(
    .CYC_W   (CYC_W),
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (start_take),
    .enable (timer_en),
    .count  (cycles),
    .expire (timer_expire)
  );

`ifdef RISC_LOADER_VERIFY_EN
  logic [DATA_W-1:0] shadow_mem [DEPTH];
  logic [DATA_W-1:0] shadow_q;
  logic [ADDR_W-1:0] last_reg;
  logic [ADDR_W-1:0] vaddr_reg;
  logic              issue_done_reg;
  logic              cmp_valid_reg;
  logic [ADDR_W-1:0] cmp_addr_reg;
  logic              verify_bad;
  logic              verify_last;

  // shadow copy of every accepted byte; read follows the issued read address
  always_ff @(posedge clk) begin
    if (handshake) begin
      shadow_mem[ptr_reg] <= in_data;
    end
    shadow_q <= shadow_mem[mem_addr];
  end

  // align the compare with memory read data, one cycle after mem_re
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmp_valid_reg <= 1'b0;
      cmp_addr_reg  <= '0;
    end else begin
      cmp_valid_reg <= mem_re;
      cmp_addr_reg  <= mem_addr;
    end
  end

  assign verify_bad  = cmp_valid_reg && (mem_rdata != shadow_q);
  assign verify_last = cmp_valid_reg && (cmp_addr_reg == last_reg);
`else
  logic unused_rdata;
  assign unused_rdata = ^mem_rdata;
  assign mem_re       = 1'b0;
`endif

  // loader sequencing: load, optional read-back, CPU reset hold, run, report
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
      ptr_reg   <= '0;
      hold_reg  <= '0;
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_rst   <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      err_code  <= ERR_NONE;
`ifdef RISC_LOADER_VERIFY_EN
      mem_re         <= 1'b0;
      last_reg       <= '0;
      vaddr_reg      <= '0;
      issue_done_reg <= 1'b0;
`endif
    end else begin
      mem_we <= 1'b0;
`ifdef RISC_LOADER_VERIFY_EN
      mem_re <= 1'b0;
`endif
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_reg <= ST_LOAD;
            ptr_reg   <= '0;
            done      <= 1'b0;
            err_code  <= ERR_NONE;
            in_ready  <= 1'b1;
            busy      <= 1'b1;
            cpu_rst   <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (handshake) begin
            mem_we    <= 1'b1;
            mem_addr  <= ptr_reg;
            mem_wdata <= in_data;
            if (ptr_reg != LAST_ADDR) begin
              ptr_reg <= ptr_reg + 1'b1;
            end
            if (load_end) begin
              in_ready <= 1'b0;
`ifdef RISC_LOADER_VERIFY_EN
              state_reg      <= ST_VERIFY;
              last_reg       <= ptr_reg;
              vaddr_reg      <= '0;
              issue_done_reg <= 1'b0;
`else
              state_reg <= ST_CPURST;
              hold_reg  <= '0;
`endif
            end
          end
        end
`ifdef RISC_LOADER_VERIFY_EN
        ST_VERIFY: begin
          if (!issue_done_reg) begin
            mem_re   <= 1'b1;
            mem_addr <= vaddr_reg;
            if (vaddr_reg == last_reg) begin
              issue_done_reg <= 1'b1;
            end else begin
              vaddr_reg <= vaddr_reg + 1'b1;
            end
          end
          if (verify_bad) begin
            state_reg <= ST_DONE;
            done      <= 1'b1;
            err_code  <= ERR_VERIFY;
            busy      <= 1'b0;
            mem_re    <= 1'b0;
          end else if (verify_last) begin
            state_reg <= ST_CPURST;
            hold_reg  <= '0;
          end
        end
`endif
        ST_CPURST: begin
          if (hold_reg == HOLD_LAST) begin
            state_reg <= ST_RUN;
            cpu_rst   <= 1'b0;
          end else begin
            hold_reg <= hold_reg + 1'b1;
          end
        end
        ST_RUN: begin
          if (halt) begin
            // CPU left out of reset so its state can be inspected
            state_reg <= ST_DONE;
            done      <= 1'b1;
            err_code  <= ERR_NONE;
            busy      <= 1'b0;
          end else if (timer_expire) begin
            state_reg <= ST_DONE;
            done      <= 1'b1;
            err_code  <= ERR_TIMEOUT;
            busy      <= 1'b0;
            cpu_rst   <= 1'b1;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          in_ready  <= 1'b0;
          busy      <= 1'b0;
          cpu_rst   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_risc_prog_loader.sv
`timescale 1ns/1ps
// tb_risc_prog_loader: drives directed and random programs through the
// loader, emulates the memory and an 8-clock-per-instruction CPU, and checks
// results against an arithmetic model of program execution.
module tb_risc_prog_loader;
  import risc_loader_pkg::*;

  localparam int TIMEOUT = 100;
  localparam int DEPTH   = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_last = 1'b0;
  logic        in_ready, mem_we, mem_re, cpu_rst, halt, busy, done;
  logic [4:0]  mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic [1:0]  err_code;
  logic [15:0] cycles;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  risc_prog_loader #(
    .ADDR_W(5), .DATA_W(8), .CYC_W(16), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .cpu_rst(cpu_rst),
    .halt(halt), .busy(busy), .done(done), .err_code(err_code),
    .cycles(cycles)
  );

  // program memory seen by the loader and the CPU
  logic [7:0] phys_mem [DEPTH];
  logic       mem_fill = 1'b1;
  logic       fault_addr1 = 1'b0;
  logic [7:0] rdata_q = 8'd0;
  always @(posedge clk) begin
    if (mem_fill) begin
      for (int i = 0; i < DEPTH; i++) phys_mem[i] <= 8'hE0 ^ 8'(i);
    end else if (mem_we) begin
      phys_mem[mem_addr] <= mem_wdata;
    end
    if (mem_re) rdata_q <= phys_mem[mem_addr] ^ {7'd0, fault_addr1 && (mem_addr == 5'd1)};
  end
  assign mem_rdata = rdata_q;

  // write log and side-channel counters
  logic [4:0] wr_addr_q [$];
  logic [7:0] wr_data_q [$];
  int re_count = 0;
  int cpu_run_count = 0;
  always @(posedge clk) begin
    if (mem_we) begin
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_wdata);
    end
    if (mem_re) re_count <= re_count + 1;
    if (!cpu_rst) cpu_run_count <= cpu_run_count + 1;
  end

  // CPU stand-in: 8 phases per instruction, HLT raises halt in phase 4
  logic [2:0] cpu_phase = 3'd0;
  logic [4:0] cpu_pc = 5'd0;
  logic       cpu_halted = 1'b0;
  always @(posedge clk) begin
    if (cpu_rst) begin
      cpu_phase  <= 3'd0;
      cpu_pc     <= 5'd0;
      cpu_halted <= 1'b0;
    end else if (!cpu_halted) begin
      if (cpu_phase == 3'd4 && phys_mem[cpu_pc][7:5] == OP_HLT) begin
        cpu_halted <= 1'b1;
      end else begin
        cpu_phase <= cpu_phase + 3'd1;
        if (cpu_phase == 3'd7)
          cpu_pc <= (phys_mem[cpu_pc][7:5] == OP_JMP) ? phys_mem[cpu_pc][4:0] : cpu_pc + 5'd1;
      end
    end
  end
  assign halt = cpu_halted;

  // expected memory image, built only from what the bench streamed
  logic [7:0] model_mem [DEPTH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // instruction n (0-based) that is a HLT is seen after 8n+5 counted clocks
  function automatic void ref_run(output int ecyc, output int eerr);
    int pc;
    int n;
    logic [7:0] b;
    pc = 0; n = 0;
    ecyc = TIMEOUT; eerr = 1;
    while (8 * n + 5 < TIMEOUT) begin
      b = model_mem[pc];
      if (b[7:5] == OP_HLT) begin
        ecyc = 8 * n + 5; eerr = 0;
        return;
      end
      if (b[7:5] == OP_JMP) pc = int'(b[4:0]);
      else pc = (pc + 1) % DEPTH;
      n++;
    end
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, "_cpu_rst"}, cpu_rst, 1);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_mem_we_re"}, {mem_we, mem_re}, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_busy_done"}, {busy, done}, 0);
    chk({tag, "_err"}, err_code, 0);
    chk({tag, "_cycles"}, cycles, 0);
  endtask

  task automatic send_prog(input logic [7:0] prog[$], input bit use_last,
                           input int gap_mode, output int n_acc);
    int guard;
    bit gap;
    bit tog;
    n_acc = 0; guard = 0; tog = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("load_entry", {busy, done, in_ready, cycles == 16'd0}, 4'b1011);
    while (n_acc < prog.size() && guard < 400) begin
      gap = (gap_mode == 1) ? tog : (gap_mode == 2) ? bit'($urandom_range(0, 1)) : 1'b0;
      tog = ~tog;
      if (gap) begin
        in_valid = 1'b0; in_last = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_data  = prog[n_acc];
        in_last  = use_last && (n_acc == prog.size() - 1);
        if (in_ready) begin
          model_mem[n_acc] = prog[n_acc];
          n_acc++;
        end
      end
      @(posedge clk); #1;
      guard++;
    end
    in_valid = 1'b0; in_last = 1'b0;
    chk("load_guard", guard < 400, 1);
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while (!done && k < 3000) begin
      @(posedge clk); #1;
      k++;
    end
    chk({tag, "_done"}, done, 1);
  endtask

  task automatic run_prog(input string tag, input logic [7:0] prog[$],
                          input bit use_last, input int gap_mode);
    int base, n, ecyc, eerr;
    base = wr_addr_q.size();
    send_prog(prog, use_last, gap_mode, n);
    if (!use_last) begin
      in_valid = 1'b1; in_data = 8'h5A;
      for (int i = 0; i < 2; i++) begin
        chk({tag, "_extra_not_ready"}, in_ready, 0);
        @(posedge clk); #1;
      end
      in_valid = 1'b0;
    end
    wait_done(tag);
    ref_run(ecyc, eerr);
    chk({tag, "_err"}, err_code, eerr);
    chk({tag, "_cycles"}, cycles, ecyc);
    chk({tag, "_cpu_rst"}, cpu_rst, (eerr != 0) ? 1 : 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_nwrites"}, wr_addr_q.size() - base, prog.size());
    for (int i = 0; i < n && base + i < wr_addr_q.size(); i++) begin
      chk({tag, "_wr_addr"}, wr_addr_q[base + i], i);
      chk({tag, "_wr_data"}, wr_data_q[base + i], prog[i]);
    end
    $display("run %s len=%0d accepted=%0d cycles=%0d err=%0d", tag, prog.size(), n, cycles, err_code);
  endtask

  initial begin
    logic [7:0] prog [$];
    int n;
    int base;
    int run_base;

    for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'hE0 ^ 8'(i);
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("reset");
    rst = 1'b1;
    mem_fill = 1'b0;
    @(posedge clk); #1;

    // 1: single HLT at address 0
    prog = '{8'h00};
    run_prog("t1_hlt", prog, 1'b1, 0);
    chk("t1_cycles_const", cycles, 5);
    chk("t1_cpu_stays_run", cpu_rst, 0);

    // 2: JMP 2, JMP 2, HLT with gapped valid
    prog = '{8'hE2, 8'hE2, 8'h00};
    run_prog("t2_jmp", prog, 1'b1, 1);
    chk("t2_cycles_const", cycles, 13);

    // 3: full memory without in_last
    prog = {};
    for (int i = 0; i < DEPTH; i++) prog.push_back(8'($urandom));
    run_prog("t3_full", prog, 1'b0, 0);

    // 4: JMP 0 forever -> timeout
    prog = '{8'hE0};
    run_prog("t4_timeout", prog, 1'b1, 0);
    chk("t4_err_const", err_code, 1);
    chk("t4_cycles_const", cycles, TIMEOUT);
    chk("t4_cpu_rst_const", cpu_rst, 1);

    // random programs with random valid gaps
    for (int r = 0; r < 6; r++) begin
      int len;
      len = $urandom_range(1, DEPTH);
      prog = {};
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 5) == 0) prog.push_back({OP_HLT, 5'($urandom)});
        else prog.push_back(8'($urandom));
      end
      run_prog("rand", prog, 1'b1, 2);
    end

    // 5: async reset in the middle of a load, then reload
    prog = '{8'h21, 8'h42, 8'h63};
    send_prog(prog, 1'b0, 0, n);
    chk("t5_partial_accepted", n, 3);
    chk("t5_still_busy", busy, 1);
    @(posedge clk); #1;
    #2 rst = 1'b0;
    #1;
    chk_reset("t5_abort");
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    prog = '{8'h00};
    run_prog("t5_reload", prog, 1'b1, 0);
    chk("t5_reload_cycles", cycles, 5);

`ifdef RISC_LOADER_VERIFY_EN
    // 6: read-back mismatch at address 1 keeps the CPU in reset
    prog = '{8'hE2, 8'hE2, 8'h00};
    base = wr_addr_q.size();
    fault_addr1 = 1'b1;
    send_prog(prog, 1'b1, 1, n);
    run_base = cpu_run_count;
    wait_done("t6_fault");
    chk("t6_fault_err", err_code, 2);
    chk("t6_fault_cycles", cycles, 0);
    chk("t6_fault_cpu_rst", cpu_rst, 1);
    chk("t6_fault_cpu_never_ran", cpu_run_count - run_base, 0);
    chk("t6_fault_nwrites", wr_addr_q.size() - base, 3);
    $display("run t6_fault cycles=%0d err=%0d", cycles, err_code);
    fault_addr1 = 1'b0;
    run_prog("t6_clean", prog, 1'b1, 1);
    chk("t6_clean_cycles", cycles, 13);
`else
    chk("no_read_strobe", re_count, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
